prng_sample_source: RTL
=======================

// Module: prng_sample_source
// PURPOSE
//   Upstream stage of the running-compare circuit. Replaces the $random stimulus with a
//   synthesizable Galois LFSR that emits exactly N_SAMPLES W-bit pseudo-random words
//   over a valid/ready handshake. Flags the final word and reports completion, so the
//   consumer stops on the handshake rather than on its own iteration counter.
// PARAMETERS
//   W         32            data width; LFSR length (W >= 8)
//   N_SAMPLES 99            words emitted per run (1 .. 2**CNT_W-1)
//   CNT_W     7             sample counter width
//   SEED      32'hACE12468  reset/default seed; also substituted for a zero seed
//   TAPS      32'h80200003  Galois feedback mask (x^32+x^22+x^2+x+1), W bits
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      1-cycle pulse: begin a run (honoured in IDLE/DONE only)
//   seed_ld    in   1      load seed_i into LFSR (honoured in IDLE/DONE only)
//   seed_i     in   W      seed value
//   out_valid  out  1      out_data holds a valid sample
//   out_ready  in   1      consumer accepts the sample this cycle
//   out_data   out  W      current LFSR state
//   out_last   out  1      high with out_valid on the N_SAMPLES-th word
//   busy       out  1      FSM in RUN
//   done       out  1      sticky: run completed; cleared by start or rst
//   count      out  CNT_W  words accepted in the current/last run
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge): state=IDLE, lfsr=SEED, count=0, out_valid=0,
//     out_last=0, busy=0, done=0. Reset overrides all other inputs; a run aborts on reset.
//   LFSR step: s' = (s >> 1) ^ (s[0] ? TAPS : 0). State is never zero.
//   Seed load: seed_ld in IDLE/DONE -> lfsr <= (seed_i==0) ? SEED : seed_i next cycle.
//     Ignored in RUN. seed_ld and start in the same cycle: seed applies first, run
//     begins next cycle with the new seed as its first word.
//   FSM:
//     IDLE -> RUN  on start; count<=0, done<=0.
//     RUN  : out_valid=1, out_data=lfsr (registered, zero combinational input->output path).
//            Handshake fire = out_valid & out_ready: lfsr steps, count+1.
//            No fire: out_data, out_last stable (AXI-style hold; valid is never dropped).
//            Fire with count==N_SAMPLES-1 -> DONE.
//            start in RUN: ignored.
//     DONE : out_valid=0, done=1, busy=0; lfsr keeps the state after the last word, so a
//            new start without seed_ld continues the sequence.
//     DONE -> RUN on start (count<=0, done<=0).
//   out_last = out_valid & (count==N_SAMPLES-1).
//   Latency: start at cycle t -> out_valid=1 at t+1. Back-to-back fires: one word/cycle.
//   N_SAMPLES=1: first word carries out_last; DONE after one fire.
//   count saturates by construction (never exceeds N_SAMPLES); no wrap.
//   The unused 2-bit state encoding 2'b11 returns to IDLE.
// STRUCTURE
//   Shared package/header: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
//     default SEED and TAPS constants.
//   Sub-module prng_lfsr (W, TAPS): register with synchronous rst-to-seed, load and step
//     enables (load wins); outputs state. The top holds the FSM, counter and handshake.
// TESTING
//   1 Reset: rst high for 2 cycles -> out_valid=0, done=0, count=0, busy=0.
//   2 SEED=1, start, out_ready=1 -> out_data 0x00000001, 0x80200003, 0xC0300002 on
//     consecutive cycles.
//   3 N_SAMPLES=99, out_ready=1 -> 99 fires, out_last only on fire 99, done=1, count=99,
//     out_valid=0 afterwards.
//   4 Random out_ready backpressure (~50%) -> out_data/out_last stable while stalled;
//     sequence identical to test 3; still exactly 99 fires.
//   5 seed_ld with seed_i=0 in IDLE, then start -> first word = SEED; seed_ld in RUN ->
//     sequence unchanged.
//   6 rst asserted at word 40 -> next cycle IDLE, out_valid=0, lfsr=SEED; start then
//     replays the word sequence from word 1.

Source files
------------

// File: rtl/prng_sample_source_pkg.sv
// Shared definitions for the PRNG sample source: FSM state encoding and the
// default seed / feedback constants.
package prng_sample_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEF_SEED = 32'hACE12468;
  // x^32 + x^22 + x^2 + x + 1 in Galois (right-shift) form
  localparam logic [31:0] DEF_TAPS = 32'h80200003;

endpackage

// File: rtl/prng_lfsr.sv
// Galois LFSR register: synchronous reset to SEED, parallel load and single-step
// enables, with load taking priority over step.
module prng_lfsr #(
  parameter int             W    = 32,
  parameter logic [W-1:0]   TAPS = W'(32'h80200003),
  parameter logic [W-1:0]   SEED = W'(32'hACE12468)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         step_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_val_i;
    end else if (step_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/prng_sample_source.sv
// Emits N_SAMPLES pseudo-random words from a Galois LFSR over valid/ready,
// flagging the final word and holding a sticky done flag afterwards.
module prng_sample_source
  import prng_sample_source_pkg::*;
#(
  parameter int           W         = 32,
  parameter int           N_SAMPLES = 99,
  parameter int           CNT_W     = 7,
  parameter logic [W-1:0] SEED      = W'(DEF_SEED),
  parameter logic [W-1:0] TAPS      = W'(DEF_TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             seed_ld,
  input  logic [W-1:0]     seed_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             fire;
  logic             can_load;
  logic [W-1:0]     load_val;

  assign out_valid = (state_q == ST_RUN);
  assign fire      = out_valid & out_ready;
  assign can_load  = seed_ld & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  // A zero seed would lock the LFSR at zero forever
  assign load_val  = (seed_i == '0) ? SEED : seed_i;

  prng_lfsr #(
    .W    (W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (can_load),
    .load_val_i (load_val),
    .step_i     (fire),
    .state_o    (out_data)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          count_d = '0;
          done_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (fire) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign out_last = out_valid & (count_q == LAST_CNT);
  assign busy     = out_valid;
  assign done     = done_q;
  assign count    = count_q;

endmodule
